// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversample tick, rx synchroniser, start/data/parity/stop
// framing and a one-deep holding register presented through a valid/ready handshake.
module uart_rx_deserializer #(
  parameter int SYNC_STAGES = 2,
  parameter int OVERSAMPLE  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor_i,
  input  logic [1:0]  wlen_i,
  input  logic        par_en_i,
  input  logic        par_even_i,
  input  logic        par_stick_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        par_err_o,
  output logic        frame_err_o,
  output logic        break_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] MID_IDX  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRKWAIT
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic [15:0]             tick_cnt;
  logic                    tick;
  logic [SCNT_W-1:0]       scnt;
  logic [2:0]              bitcnt;
  logic [2:0]              last_bit;
  logic [7:0]              shreg;
  logic                    par_bit;
  logic [7:0]              data_mask;
  logic [7:0]              rx_data;
  logic                    par_expect;

  // NOTE: every register here uses non-blocking assignments so all flops see
  // pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Divisor 0 parks the counter at 0 with no tick; a new divisor is picked up at reload.
  assign tick = (divisor_i != 16'd0) && (tick_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst || divisor_i == 16'd0) tick_cnt <= 16'd0;
    else if (tick)                 tick_cnt <= divisor_i - 16'd1;
    else                           tick_cnt <= tick_cnt - 16'd1;
  end

  assign last_bit = {1'b0, wlen_i} + 3'd4;

  always_comb begin
    case (wlen_i)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
    rx_data = shreg & data_mask;
    if (par_stick_i)     par_expect = ~par_even_i;
    else if (par_even_i) par_expect = ^rx_data;
    else                 par_expect = ~^rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      scnt        <= '0;
      bitcnt      <= 3'd0;
      shreg       <= 8'h00;
      par_bit     <= 1'b0;
      busy_o      <= 1'b0;
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      par_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
      break_o     <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (divisor_i == 16'd0) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
        scnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tick && !rx_s) begin
              state  <= ST_START;
              scnt   <= '0;
              busy_o <= 1'b1;
            end
          end
          ST_START: begin
            if (tick) begin
              if (scnt == MID_IDX) begin
                if (rx_s) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                end else begin
                  state  <= ST_DATA;
                  scnt   <= '0;
                  bitcnt <= 3'd0;
                  shreg  <= 8'h00;
                end
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              scnt <= (scnt == LAST_IDX) ? '0 : scnt + 1'b1;
              if (scnt == LAST_IDX) begin
                shreg[bitcnt] <= rx_s;
                // >= rather than == so a mid-frame word-length change cannot strand the FSM.
                if (bitcnt >= last_bit) state <= par_en_i ? ST_PARITY : ST_STOP;
                else                    bitcnt <= bitcnt + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (tick) begin
              scnt <= (scnt == LAST_IDX) ? '0 : scnt + 1'b1;
              if (scnt == LAST_IDX) begin
                par_bit <= rx_s;
                state   <= ST_STOP;
              end
            end
          end
          ST_STOP: begin
            if (tick) begin
              scnt <= (scnt == LAST_IDX) ? '0 : scnt + 1'b1;
              if (scnt == LAST_IDX) begin
                state  <= rx_s ? ST_IDLE : ST_BRKWAIT;
                busy_o <= ~rx_s;
                // Holding register accepts if empty or being drained this very cycle.
                if (!valid_o || ready_i) begin
                  data_o      <= rx_data;
                  valid_o     <= 1'b1;
                  par_err_o   <= par_en_i && (par_bit != par_expect);
                  frame_err_o <= ~rx_s;
                  break_o     <= ~rx_s && (rx_data == 8'h00) && !(par_en_i && par_bit);
                end else begin
                  overrun_o <= 1'b1;
                end
              end
            end
          end
          ST_BRKWAIT: begin
            if (rx_s) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
